rcb_reg_arbiter: RTL and testbench

- Shares the RCB register-file bus (addr / data_mosi / data_mosi_rdy / data_miso) between two requesters: port 0 is the SPI slave and port 1 is the local self-test/maintenance sequencer.
- Serialises single-word read and write transactions, holds the address stable for a configurable settle time, and returns read data with a one-cycle ack.
- Sits between the requesters and the register file in rcb_top.

---
 rtl/rcb_reg_arbiter_pkg.sv | 33 +++
 rtl/rcb_reg_arbiter_if.sv | 18 +
 rtl/rcb_reg_arbiter_rr.sv | 38 +++
 rtl/rcb_reg_arbiter.sv | 139 +++++++++++++
 tb/tb_rcb_reg_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rcb_reg_arbiter_pkg.sv
// Shared constants for the RCB register-file arbiter: FSM encodings,
// the idle bus address and the register address map.
package rcb_reg_arbiter_pkg;

    // FSM encodings, kept as plain constants for legacy tooling.
    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_ADDR   = 2'd1;
    localparam logic [1:0] ARB_ACCESS = 2'd2;
    localparam logic [1:0] ARB_ACK    = 2'd3;

    // Unmapped address parked on the bus while idle; reads back all ones.
    localparam logic [15:0] REG_IDLE_ADDR = 16'hFFFF;

    // Register address map.
    localparam logic [15:0] REG_ID      = 16'h0000;
    localparam logic [15:0] REG_CTRL    = 16'h0004;
    localparam logic [15:0] REG_STATUS  = 16'h0008;
    localparam logic [15:0] REG_SCRATCH = 16'h0010;

    // One requester's transaction as captured at grant time.
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } arb_txn_t;

    // Select the winning requester's transaction.
    function automatic arb_txn_t pick_txn(input logic idx, input arb_txn_t t0,
                                          input arb_txn_t t1);
        return idx ? t1 : t0;
    endfunction

endpackage

// File: rtl/rcb_reg_arbiter_if.sv
// Register-file side of the arbiter (addr / data_mosi / data_mosi_rdy /
// data_miso).
//
// Handshake: the arbiter (master) holds reg_addr and reg_wdata stable for
// the whole address-settle and access window; reg_wr is a single-cycle
// write strobe in the access cycle. The register file (slave) answers
// reg_rdata combinationally from reg_addr with no flow control of its own.
interface rcb_reg_arbiter_if;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic [31:0] reg_rdata;

    modport master (output reg_addr, output reg_wdata, output reg_wr,
                    input reg_rdata);
    modport slave  (input reg_addr, input reg_wdata, input reg_wr,
                    output reg_rdata);
endinterface

// File: rtl/rcb_reg_arbiter_rr.sv
// Two-input grant: round-robin on last_grant, or port 0 fixed priority.
// The grant is combinational and only consumed while the arbiter is idle.
module rcb_rr_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk_100m,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic upd_idx,
    output logic gnt_valid,
    output logic gnt_idx
);

    logic last_grant;

    // Pick the winner; on contention prefer the port not served last.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = 1'b0;
        if (req0 && req1) begin
            gnt_idx = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else if (req1) begin
            gnt_idx = 1'b1;
        end
    end

    // Remember the last served port; reset to 1 so port 0 wins first.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= upd_idx;
        end
    end

endmodule

// File: rtl/rcb_reg_arbiter.sv
// Serialises single-word register reads/writes from the SPI slave (port 0)
// and the self-test sequencer (port 1) onto the shared RCB register bus.
module rcb_reg_arbiter
    import rcb_reg_arbiter_pkg::*;
#(
    parameter int          SETUP_CYC  = 2,
    parameter logic [15:0] IDLE_ADDR  = REG_IDLE_ADDR,
    parameter int          FIXED_PRIO = 0
) (
    input  logic             clk_100m,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [15:0]      addr0,
    input  logic [15:0]      addr1,
    input  logic [31:0]      wdata0,
    input  logic [31:0]      wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [31:0]      rdata0,
    output logic [31:0]      rdata1,
    output logic             busy,
    output logic [1:0]       arb_state,
    rcb_reg_arbiter_if.master rf
);

    // The settle counter is 4 bits, so only 1..15 settle cycles fit.
    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup_cyc
            $error("rcb_reg_arbiter: SETUP_CYC must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LAST = 4'(SETUP_CYC - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       lat_we;
    logic       gidx;
    logic       gnt_valid;
    logic       gnt_idx;
    arb_txn_t   txn0;
    arb_txn_t   txn1;
    arb_txn_t   cand;

    assign arb_state = state;

    // Bundle each requester's inputs and select the one being granted.
    always_comb begin
        txn0 = '{we: we0, addr: addr0, wdata: wdata0};
        txn1 = '{we: we1, addr: addr1, wdata: wdata1};
        cand = pick_txn(gnt_idx, txn0, txn1);
    end

    rcb_rr_arbiter #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr (
        .clk_100m  (clk_100m),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .update    (state == ARB_ACK),
        .upd_idx   (gidx),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Transaction FSM and bus drivers; the bus registers double as the
    // latched address/data, so later requester changes cannot leak in.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state        <= ARB_IDLE;
            cnt          <= 4'd0;
            lat_we       <= 1'b0;
            gidx         <= 1'b0;
            busy         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rf.reg_addr  <= IDLE_ADDR;
            rf.reg_wdata <= 32'd0;
            rf.reg_wr    <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rf.reg_wr <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        lat_we       <= cand.we;
                        gidx         <= gnt_idx;
                        cnt          <= 4'd0;
                        rf.reg_addr  <= cand.addr;
                        rf.reg_wdata <= cand.wdata;
                        busy         <= 1'b1;
                        state        <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        rf.reg_wr <= lat_we;
                        state     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    ack0         <= ~gidx;
                    ack1         <= gidx;
                    rf.reg_addr  <= IDLE_ADDR;
                    rf.reg_wdata <= 32'd0;
                    state        <= ARB_ACK;
                end
                ARB_ACK: begin
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Capture read data into the granted port only, at the end of ACCESS.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            rdata0 <= 32'd0;
            rdata1 <= 32'd0;
        end else if (state == ARB_ACCESS && !lat_we) begin
            if (gidx) begin
                rdata1 <= rf.reg_rdata;
            end else begin
                rdata0 <= rf.reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rcb_reg_arbiter.sv
// Bench for rcb_reg_arbiter: four instances share the requester inputs
// (0: SETUP_CYC=2 round-robin, 1: SETUP_CYC=2 fixed priority,
//  2: SETUP_CYC=1, 3: SETUP_CYC=15), each with its own register-file model.
module tb_rcb_reg_arbiter;

    // ---------------- clock / reset ----------------
    logic clk_100m = 1'b0;
    logic rst      = 1'b1;
    always #5 clk_100m = ~clk_100m;

    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = 16'd0, addr1 = 16'd0;
    logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;

    wire  [3:0]  ack0_v, ack1_v, busy_v, reg_wr_v;
    wire  [31:0] rd0_v [4];
    wire  [31:0] rd1_v [4];
    wire  [31:0] reg_wdata_v [4];
    wire  [15:0] reg_addr_v [4];
    wire  [1:0]  state_v [4];

    localparam logic [3:0][3:0] SC_V = {4'd15, 4'd1, 4'd2, 4'd2};
    localparam logic [3:0]      FP_V = 4'b0010;

    // Register file: a few mapped registers, everything else reads all ones.
    function automatic logic [31:0] rf_read(input logic [15:0] a);
        case (a)
            16'h0000: return 32'h0000_0102;
            16'h0008: return 32'h0000_CAFE;
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rcb_reg_arbiter_if u_if ();
        assign u_if.reg_rdata  = rf_read(u_if.reg_addr);
        assign reg_addr_v[g]   = u_if.reg_addr;
        assign reg_wdata_v[g]  = u_if.reg_wdata;
        assign reg_wr_v[g]     = u_if.reg_wr;
        rcb_reg_arbiter #(
            .SETUP_CYC  (int'(SC_V[g])),
            .IDLE_ADDR  (16'hFFFF),
            .FIXED_PRIO (int'(FP_V[g]))
        ) u_dut (
            .clk_100m  (clk_100m),
            .rst       (rst),
            .req0      (req0),
            .req1      (req1),
            .we0       (we0),
            .we1       (we1),
            .addr0     (addr0),
            .addr1     (addr1),
            .wdata0    (wdata0),
            .wdata1    (wdata1),
            .ack0      (ack0_v[g]),
            .ack1      (ack1_v[g]),
            .rdata0    (rd0_v[g]),
            .rdata1    (rd1_v[g]),
            .busy      (busy_v[g]),
            .arb_state (state_v[g]),
            .rf        (u_if)
        );
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rd [2];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // One transaction on instance 0, starting in IDLE. 'mutate' scrambles the
    // requester inputs and drops req at N+2 to prove the latch holds.
    task automatic run_txn(input logic port, input logic we,
                           input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_own, input bit mutate,
                           input string tag);
        int          edges = 0;
        int          wr_cnt = 0;
        int          wr_edge = 0;
        int          addr_cyc = 0;
        int          busy_cyc = 0;
        int          other_ack = 0;
        bit          got = 1'b0;
        logic [31:0] wr_data = 32'd0;
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        while (!got && edges < 40) begin
            tick();
            edges++;
            if (edges == (mutate ? 2 : 1)) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (mutate && edges == 2) begin
                we0 = ~we; addr0 = addr ^ 16'h00F0; wdata0 = ~wdata;
                we1 = ~we; addr1 = addr ^ 16'h00F0; wdata1 = ~wdata;
            end
            if (reg_wr_v[0]) begin
                wr_cnt++;
                wr_edge = edges;
                wr_data = reg_wdata_v[0];
            end
            if (reg_addr_v[0] == addr) addr_cyc++;
            if (busy_v[0]) busy_cyc++;
            if (port ? ack0_v[0] : ack1_v[0]) other_ack++;
            if (port ? ack1_v[0] : ack0_v[0]) got = 1'b1;
        end
        check({tag, " ack seen"}, 64'(got), 64'd1);
        check({tag, " ack latency"}, 64'(edges), 64'd4);
        check({tag, " reg_wr count"}, 64'(wr_cnt), we ? 64'd1 : 64'd0);
        if (we) begin
            check({tag, " reg_wr cycle"}, 64'(wr_edge), 64'd3);
            check({tag, " reg_wdata at strobe"}, 64'(wr_data), 64'(wdata));
        end
        check({tag, " reg_addr hold"}, 64'(addr_cyc), 64'd3);
        check({tag, " busy cycles"}, 64'(busy_cyc), 64'd4);
        check({tag, " other ack"}, 64'(other_ack), 64'd0);
        exp_rd[port] = exp_own;
        check({tag, " own rdata"}, port ? 64'(rd1_v[0]) : 64'(rd0_v[0]),
              64'(exp_rd[port]));
        check({tag, " other rdata"}, port ? 64'(rd0_v[0]) : 64'(rd1_v[0]),
              64'(exp_rd[~port]));
        tick();
        check({tag, " idle state"}, 64'(state_v[0]), 64'd0);
        check({tag, " idle busy"}, 64'(busy_v[0]), 64'd0);
        check({tag, " idle reg_addr"}, 64'(reg_addr_v[0]), 64'hFFFF);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_own;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        int          n_main, n_fp, guard, both, bad, e, lat1, lat15;
        logic [3:0]  ord_main, ord_fp;

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 32'h0000_0101, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0102};
        vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 1'b1, 16'h0004, 32'hDEAD_BEEF, 32'h0000_0102};
        vecs[4] = '{1'b0, 1'b0, 16'h0008, 32'h0000_0000, 32'h0000_CAFE};
        vecs[5] = '{1'b1, 1'b0, 16'h7FFF, 32'h0000_0000, 32'hFFFF_FFFF};
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;

        // Reset values.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset state", 64'(state_v[0]), 64'd0);
        check("reset reg_addr", 64'(reg_addr_v[0]), 64'hFFFF);
        check("reset reg_wdata", 64'(reg_wdata_v[0]), 64'd0);
        check("reset reg_wr", 64'(reg_wr_v[0]), 64'd0);
        check("reset acks", 64'({ack0_v[0], ack1_v[0]}), 64'd0);
        check("reset rdata0", 64'(rd0_v[0]), 64'd0);
        check("reset rdata1", 64'(rd1_v[0]), 64'd0);
        check("reset busy", 64'(busy_v[0]), 64'd0);

        // Single transactions from the table.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_own, 1'b0, $sformatf("vec%0d", i));
        end

        // Contention with both requests held: round-robin vs fixed priority.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0008;
        n_main = 0; n_fp = 0; guard = 0; both = 0;
        ord_main = 4'd0; ord_fp = 4'd0;
        while ((n_main < 4 || n_fp < 4) && guard < 60) begin
            tick();
            guard++;
            if (ack0_v[0] && ack1_v[0]) both++;
            if (ack0_v[1] && ack1_v[1]) both++;
            if (ack0_v[0] || ack1_v[0]) begin
                if (n_main < 4) ord_main[n_main] = ack1_v[0];
                n_main++;
            end
            if (ack0_v[1] || ack1_v[1]) begin
                if (n_fp < 4) ord_fp[n_fp] = ack1_v[1];
                n_fp++;
            end
            if (n_main >= 4 && n_fp >= 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (6) begin
            tick();
            if (ack0_v[0] || ack1_v[0]) n_main++;
        end
        check("rr grant order", 64'(ord_main), 64'b1010);
        check("fixed prio grant order", 64'(ord_fp), 64'b0000);
        check("rr ack count", 64'(n_main), 64'd4);
        check("dual ack", 64'(both), 64'd0);
        exp_rd[0] = 32'h0000_0102;
        exp_rd[1] = 32'h0000_CAFE;
        check("rr rdata0", 64'(rd0_v[0]), 64'(exp_rd[0]));
        check("rr rdata1", 64'(rd1_v[0]), 64'(exp_rd[1]));

        // Requester inputs change and req drops mid-transaction.
        run_txn(1'b0, 1'b1, 16'h0020, 32'h0000_1111, 32'h0000_0102, 1'b1,
                "latched");

        // Reset during the ACCESS cycle of a write.
        we0 = 1'b1; addr0 = 16'h0040; wdata0 = 32'h0000_4444; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        check("pre-reset reg_wr", 64'(reg_wr_v[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst reg_wr", 64'(reg_wr_v[0]), 64'd0);
        check("rst reg_addr", 64'(reg_addr_v[0]), 64'hFFFF);
        check("rst busy", 64'(busy_v[0]), 64'd0);
        bad = 0;
        repeat (2) begin
            tick();
            if (ack0_v[0] || ack1_v[0] || reg_wr_v[0]) bad++;
        end
        rst = 1'b0;
        repeat (5) begin
            tick();
            if (ack0_v[0] || ack1_v[0] || reg_wr_v[0]) bad++;
        end
        check("no ack or strobe after reset", 64'(bad), 64'd0);
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        run_txn(1'b0, 1'b0, 16'h0000, 32'd0, 32'h0000_0102, 1'b0, "post-reset");

        // Settle-time extremes: SETUP_CYC 1 and 15.
        repeat (25) tick();
        we0 = 1'b0; addr0 = 16'h7FFF; req0 = 1'b1;
        e = 0; lat1 = 0; lat15 = 0;
        while ((lat1 == 0 || lat15 == 0) && e < 40) begin
            tick();
            e++;
            if (e == 1) req0 = 1'b0;
            if (ack0_v[2] && lat1 == 0) lat1 = e;
            if (ack0_v[3] && lat15 == 0) lat15 = e;
        end
        check("setup1 ack latency", 64'(lat1), 64'd3);
        check("setup15 ack latency", 64'(lat15), 64'd17);
        check("setup1 unmapped rdata", 64'(rd0_v[2]), 64'hFFFF_FFFF);
        check("setup15 unmapped rdata", 64'(rd0_v[3]), 64'hFFFF_FFFF);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

endmodule
